// File: rtl/serial_addsub_8bits_pkg.sv
// Shared types and sizing for the serial add/subtract unit.
// Holds the FSM state encoding, the default operand width and the bit-counter width rule.
package serial_addsub_8bits_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 8;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/serial_addsub_8bits_fa.sv
// One-bit full adder used as the single arithmetic cell of the serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_8bits.sv
// Bit-serial two's complement adder/subtractor, one bit per clock, LSB first.
// State | meaning: IDLE - waiting for start; SHIFT - one bit per edge; DONE - result valid for one cycle.
module serial_addsub_8bits
    import serial_addsub_8bits_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             ovf,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             m_q, m_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             ovf_q, ovf_d;
    logic             cout_q, cout_d;

    logic             fa_sum;
    logic             fa_cout;

    // a_q doubles as the result shift register: operand bits leave at the LSB
    // while sum bits enter at the MSB, so after WIDTH shifts it holds the result.
    full_adder u_fa (
        .a    (a_q[0]),
        .b    (b_q[0] ^ m_q),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            s_q     <= '0;
            ovf_q   <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            ovf_q   <= ovf_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        carry_d = carry_q;
        s_d     = s_q;
        ovf_d   = ovf_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    m_d     = m;
                    carry_d = m;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                a_d     = {fa_sum, a_q[WIDTH-1:1]};
                b_d     = b_q >> 1;
                carry_d = fa_cout;
                if (cnt_q == LAST) begin
                    s_d     = {fa_sum, a_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    ovf_d   = carry_q ^ fa_cout;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign s    = s_q;
    assign ovf  = ovf_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_addsub_8bits.sv
// Directed bench for serial_addsub_8bits with a result scoreboard checked on each done pulse.
module tb_serial_addsub_8bits;

    typedef struct packed {
        logic [7:0] s;
        logic       ovf;
        logic       cout;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic       busy;
    logic       done;
    logic [7:0] s;
    logic       ovf;
    logic       cout;

    int   checks   = 0;
    int   failures = 0;
    int   ndone    = 0;
    exp_t sb[$];
    exp_t prev;

    serial_addsub_8bits #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .m     (m),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .ovf   (ovf),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] av, input logic [7:0] bv, input logic mv);
        logic [7:0] bb;
        logic [8:0] r;
        exp_t       e;
        bb     = mv ? ~bv : bv;
        r      = {1'b0, av} + {1'b0, bb} + {8'd0, mv};
        e.s    = r[7:0];
        e.cout = r[8];
        e.ovf  = (av[7] == bb[7]) && (r[7] != av[7]);
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            ndone++;
            check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("s", 32'(s), 32'(e.s));
                check("ovf", 32'(ovf), 32'(e.ovf));
                check("cout", 32'(cout), 32'(e.cout));
            end
        end
    end

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic mv,
                          input exp_t e, input bit glitch);
        int n;
        bit got;
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        a = av; b = bv; m = mv;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); m = 1'($urandom);
        n = 0; got = 0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_in_shift", 32'(busy), 32'd1);
            if (n == 4) begin
                check("hold_s", 32'(s), 32'(prev.s));
                check("hold_ovf", 32'(ovf), 32'(prev.ovf));
                if (glitch) begin
                    start = 1'b1; a = 8'h00; b = 8'h00;
                end
            end
            if (n == 5) start = 1'b0;
            if (done) got = 1;
        end
        check("latency", 32'(n), 32'd9);
        check("busy_in_done", 32'(busy), 32'd0);
        prev = e;
        @(negedge clk);
        check("idle_done_low", 32'(done), 32'd0);
        check("idle_busy_low", 32'(busy), 32'd0);
    endtask

    initial begin
        int         d0;
        int         n;
        logic [7:0] ra, rb;
        logic       rm;
        exp_t       e;

        prev  = '0;
        rst_n = 1'b0;
        start = 1'b1;
        a = 8'hFF; b = 8'h01; m = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);

        run_op(8'hFF, 8'h01, 1'b0, '{s: 8'h00, ovf: 1'b0, cout: 1'b1}, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, '{s: 8'h80, ovf: 1'b1, cout: 1'b0}, 1'b0);
        run_op(8'h55, 8'hAA, 1'b0, '{s: 8'hFF, ovf: 1'b0, cout: 1'b0}, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, '{s: 8'h7F, ovf: 1'b1, cout: 1'b1}, 1'b0);
        run_op(8'h6C, 8'hCA, 1'b1, '{s: 8'hA2, ovf: 1'b1, cout: 1'b0}, 1'b0);

        // Start pulse and zero operands mid-operation must be ignored.
        d0 = ndone;
        run_op(8'h3C, 8'h19, 1'b0, '{s: 8'h55, ovf: 1'b0, cout: 1'b0}, 1'b1);
        repeat (12) @(negedge clk);
        check("glitch_one_done", 32'(ndone - d0), 32'd1);

        // Back-to-back: start held high, new operands at each done.
        d0 = ndone;
        @(negedge clk);
        ra = 8'($urandom); rb = 8'($urandom); rm = 1'($urandom);
        start = 1'b1; a = ra; b = rb; m = rm;
        sb.push_back(model(ra, rb, rm));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            a = 8'($urandom); b = 8'($urandom); m = 1'($urandom);
            n = 0;
            while (n < 20) begin
                @(negedge clk);
                n++;
                check("b2b_busy", 32'(busy), 32'(!done));
                if (done) break;
            end
            check("b2b_period", 32'(n), 32'd9);
            if (i < 4) begin
                ra = 8'($urandom); rb = 8'($urandom); rm = 1'($urandom);
                a = ra; b = rb; m = rm;
                sb.push_back(model(ra, rb, rm));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_done_count", 32'(ndone - d0), 32'd5);
        prev = model(ra, rb, rm);

        // Reset after four shift edges aborts the operation.
        d0 = ndone;
        @(negedge clk);
        start = 1'b1; a = 8'h21; b = 8'h43; m = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_s", 32'(s), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(ndone - d0), 32'd0);
        prev = '0;
        run_op(8'h01, 8'h01, 1'b0, '{s: 8'h02, ovf: 1'b0, cout: 1'b0}, 1'b0);

        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rm = 1'($urandom);
            e = model(ra, rb, rm);
            run_op(ra, rb, rm, e, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_addsub_8bits.md
SERIAL_ADDSUB_8BITS -- requirements
Module: serial_addsub_8bits

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; only 8 is required to be verified.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  operation request; sampled on rising edge.
REQ-005 Port: a  input  WIDTH  operand A, two's complement.
REQ-006 Port: b  input  WIDTH  operand B, two's complement.
REQ-007 Port: m  input  1  mode: 0 = A+B, 1 = A-B.
REQ-008 Port: busy  output  1  high while an operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; result valid.
REQ-010 Port: s  output  WIDTH  result.
REQ-011 Port: ovf  output  1  signed overflow of last result.
REQ-012 Port: cout  output  1  carry out of MSB of last result.

Function
REQ-013 FSM states: IDLE, SHIFT, DONE.
REQ-014 IDLE: start=1 -> capture a, b, m into internal registers; carry register <- m; bit counter <- 0; go to SHIFT.
REQ-015 IDLE: start=0 -> stay IDLE.
REQ-016 SHIFT: each edge processes one bit, LSB first: sum bit = a_i ^ (b_i ^ m) ^ carry; carry <- full-adder carry; sum bit shifted into result register from MSB side.
REQ-017 SHIFT: exactly WIDTH edges; counter wraps from WIDTH-1 -> DONE; no extra cycle.
REQ-018 On final bit: cout <- carry out of MSB; ovf <- carry into MSB XOR carry out of MSB.
REQ-019 Latency: capture edge E; result, ovf, cout valid and done=1 in the cycle after edge E+WIDTH (8).
REQ-020 busy=1 in SHIFT only; busy=0 in IDLE and DONE.
REQ-021 done=1 in DONE only, for exactly one cycle.
REQ-022 DONE: start=1 -> capture new operands as in REQ-014, go to SHIFT (back-to-back allowed); start=0 -> IDLE.
REQ-023 start during SHIFT is ignored; inputs a, b, m changing during SHIFT have no effect on the result.
REQ-024 s, ovf, cout hold last result until the final bit edge of the next operation; not updated bit-by-bit at the outputs.
REQ-025 Arithmetic is modulo 2^WIDTH; no saturation.

Reset
REQ-026 rst_n=0 at a rising edge -> state IDLE, busy=0, done=0, s=0, ovf=0, cout=0, counter=0, carry=0.
REQ-027 Reset mid-SHIFT aborts the operation; no done pulse is produced for it.
REQ-028 Reset dominates start on the same edge.
REQ-029 First start accepted on the first edge with rst_n=1.

Structure
REQ-030 Shared package holds: state enum (IDLE, SHIFT, DONE), default WIDTH constant, counter width constant derived from WIDTH.
REQ-031 One sub-module: full_adder (1-bit a, b, cin -> sum, cout), instantiated once in the serial datapath.
REQ-032 All outputs registered; no combinational path from inputs to outputs.

Verification
REQ-033 a=FF, b=01, m=0, start pulse -> after 8 SHIFT edges done=1, s=00, cout=1, ovf=0.
REQ-034 a=7F, b=01, m=0 -> s=80, ovf=1, cout=0; a=55, b=AA, m=0 -> s=FF, ovf=0, cout=0.
REQ-035 a=80, b=01, m=1 -> s=7F, ovf=1; a=6C, b=CA, m=1 -> s=A2, ovf=1, cout=0.
REQ-036 Back-to-back: start held high continuously with new operands presented at each DONE -> one done pulse every 9 cycles, busy low only in DONE cycles, every result correct.
REQ-037 start pulse and operand changes during SHIFT (a=00, b=00) -> ignored; in-flight result unchanged, exactly one done.
REQ-038 rst_n=0 after 4 SHIFT edges -> next cycle IDLE, busy=0, s=00, ovf=0, no done; subsequent operation a=01, b=01, m=0 -> s=02.
